lake_lsu: RTL and testbench

LAKE_LSU -- requirements
Module: lake_lsu

---
 rtl/lake_pkg.sv | 24 ++
 rtl/lake_lsu_align.sv | 51 +++++
 rtl/lake_lsu.sv | 172 +++++++++++++++++
 tb/tb_lake_lsu.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lake_pkg.sv
// Shared definitions for the lake load/store unit: funct3 encodings,
// FSM state type and access-size type.
package lake_pkg;

  // Load/store funct3 encodings (stores share B/H/W with loads)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } lsu_size_t;

endpackage

// File: rtl/lake_lsu_align.sv
// Lane alignment for the LSU: byte-enable generation and write-data
// replication for the request being accepted, and extraction plus
// sign/zero extension of the read word for the load in flight.
// Purely combinational.
module lake_lsu_align
  import lake_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_sign_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Byte enables and lane replication for the outgoing access
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (st_size_i)
      BYTE: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      HALF: begin
        be_o    = 4'b0011 << st_off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Move the addressed lane down to bit 0, then extend to 32 bits
  always_comb begin
    shifted = rdata_i >> {ld_off_i, 3'b000};
    rdata_o = shifted;
    case (ld_size_i)
      BYTE:    rdata_o = {{24{ld_sign_i & shifted[7]}}, shifted[7:0]};
      HALF:    rdata_o = {{16{ld_sign_i & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lake_lsu.sv
// Lake load/store unit: accepts one load/store from execute, issues a
// single word-aligned memory request, and returns a one-cycle done pulse
// (with fault for misaligned/illegal accesses or timeout).
// Optional feature macro: LAKE_LSU_TIMEOUT_EN enables the REQ-state
// timeout counter (TIMEOUT_CYCLES); without it REQ waits for ack forever.
module lake_lsu
  import lake_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic        o_mem_req,
  input  logic        i_mem_ack,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  lsu_state_t  state_q, state_d;

  logic [29:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  lsu_size_t   size_q;
  logic        sign_q;
  logic [1:0]  off_q;
  logic        fault_q;
  logic [31:0] rdata_q;

  lsu_size_t   req_size;
  logic        req_sign;
  logic        req_fault;
  logic        accept;
  logic        tmo_hit;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_rdata;

  assign accept = i_valid && (state_q == IDLE);

  // Decode access size, signedness and fault conditions of the request
  always_comb begin
    req_size  = WORD;
    req_sign  = 1'b0;
    req_fault = 1'b0;
    case (i_funct3)
      F3_B:  begin req_size = BYTE; req_sign = 1'b1; end
      F3_H:  begin req_size = HALF; req_sign = 1'b1; req_fault = i_addr[0]; end
      F3_W:  begin req_size = WORD; req_fault = |i_addr[1:0]; end
      F3_BU: begin req_size = BYTE; req_fault = i_we; end
      F3_HU: begin req_size = HALF; req_fault = i_we | i_addr[0]; end
      default: req_fault = 1'b1;
    endcase
  end

  lake_lsu_align u_align (
    .st_size_i (req_size),
    .st_off_i  (i_addr[1:0]),
    .wdata_i   (i_wdata),
    .be_o      (st_be),
    .wdata_o   (st_wdata),
    .ld_size_i (size_q),
    .ld_off_i  (off_q),
    .ld_sign_i (sign_q),
    .rdata_i   (i_mem_rdata),
    .rdata_o   (ld_rdata)
  );

`ifdef LAKE_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q;

  assign tmo_hit = (state_q == REQ) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count REQ cycles; cleared on every accept so each request starts at 0
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == REQ) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_fault ? RESP : REQ;
      REQ:     if (i_mem_ack || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM-derived outputs
  always_comb begin
    o_ready   = (state_q == IDLE);
    o_mem_req = (state_q == REQ);
    o_done    = (state_q == RESP);
    o_fault   = (state_q == RESP) && fault_q;
  end

  // Request capture on accept, fault tracking and load-result update
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= BYTE;
      sign_q  <= 1'b0;
      off_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        fault_q <= req_fault;
        // Faulting requests never reach memory, so the bus fields stay put
        if (!req_fault) begin
          addr_q  <= i_addr[31:2];
          we_q    <= i_we;
          be_q    <= st_be;
          wdata_q <= st_wdata;
          size_q  <= req_size;
          sign_q  <= req_sign;
          off_q   <= i_addr[1:0];
        end
      end
      if (state_q == REQ) begin
        if (i_mem_ack) begin
          fault_q <= 1'b0;
          if (!we_q) rdata_q <= ld_rdata;
        end else if (tmo_hit) begin
          fault_q <= 1'b1;
        end
      end
    end
  end

  assign o_mem_addr  = {addr_q, 2'b00};
  assign o_mem_we    = we_q;
  assign o_mem_be    = be_q;
  assign o_mem_wdata = wdata_q;
  assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_lake_lsu.sv
// Self-checking bench for lake_lsu: expected completions are pushed to a
// scoreboard queue when a request is driven and popped when o_done fires.
// Build with LAKE_LSU_TIMEOUT_EN defined to also exercise the timeout.
module tb_lake_lsu;
  import lake_pkg::*;

  localparam int TMO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_fault;
  logic        o_mem_req;
  logic        i_mem_ack;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  lake_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_we        (i_we),
    .i_funct3    (i_funct3),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_fault     (o_fault),
    .o_mem_req   (o_mem_req),
    .i_mem_ack   (i_mem_ack),
    .o_mem_addr  (o_mem_addr),
    .o_mem_we    (o_mem_we),
    .o_mem_be    (o_mem_be),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rdata = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a[1:0] != 2'b00;
      3'b100:  return we;
      3'b101:  return we || a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: case (off)
                        2'd0: return 4'b0001;
                        2'd1: return 4'b0010;
                        2'd2: return 4'b0100;
                        default: return 4'b1000;
                      endcase
      3'b001, 3'b101: return off[1] ? 4'b1100 : 4'b0011;
      default:        return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'b001:  return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // One transaction: delay = extra ack wait cycles (<0: never ack);
  // hold keeps i_valid high through the transaction to show it is ignored.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] word, input int delay, input bit hold);
    exp_t e;
    exp_t got;
    logic flt;
    int   exp_lat, exp_req, n, req_n;
    bit   done;
    flt     = m_fault(we, f3, addr);
    e.fault = flt || (delay < 0);
    if (!flt && !we && delay >= 0) model_rdata = m_rdata(f3, addr[1:0], word);
    e.rdata = model_rdata;
    sb_q.push_back(e);
    exp_lat = flt ? 1 : (delay < 0 ? TMO + 1 : delay + 2);
    exp_req = flt ? 0 : (delay < 0 ? TMO : delay + 1);

    @(negedge i_clk);
    check({tag, "_ready"}, o_ready, 1'b1);
    i_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
    @(posedge i_clk);
    #1;
    if (!hold) i_valid = 1'b0;
    i_addr  = addr ^ 32'h0000_0F0D;
    i_wdata = ~wd;

    n = 0; req_n = 0; done = 0;
    while (!done && n < 60) begin
      @(negedge i_clk);
      n++;
      if (o_mem_req) begin
        req_n++;
        if (req_n == 1 || (delay >= 0 && req_n == delay + 1)) begin
          check({tag, "_maddr"}, o_mem_addr, {addr[31:2], 2'b00});
          check({tag, "_mbe"},   o_mem_be,   m_be(f3, addr[1:0]));
          check({tag, "_mwe"},   o_mem_we,   we);
          if (we) check({tag, "_mwdata"}, o_mem_wdata, m_wdata(f3, wd));
        end
        i_mem_ack   = (delay >= 0) && (req_n == delay + 1);
        i_mem_rdata = i_mem_ack ? word : 32'hDEAD_BEEF;
      end else begin
        i_mem_ack = 1'b0;
      end
      if (o_done) begin
        done    = 1;
        i_valid = 1'b0;
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_reqcycles"}, req_n, exp_req);
        if (sb_q.size() == 0) begin
          check({tag, "_sb_empty"}, 1, 0);
        end else begin
          got = sb_q.pop_front();
          check({tag, "_fault"}, o_fault, got.fault);
          check({tag, "_rdata"}, o_rdata, got.rdata);
        end
      end
    end
    if (!done) check({tag, "_no_done"}, 0, 1);
    @(negedge i_clk);
    check({tag, "_ready_after"}, o_ready, 1'b1);
    check({tag, "_done_pulse"}, o_done, 1'b0);
  endtask

  initial begin
    int done_seen;
    i_rst = 1'b1; i_valid = 1'b0; i_addr = '0; i_wdata = '0; i_we = 1'b0;
    i_funct3 = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    #12;
    check("rst_ready",  o_ready,    1'b1);
    check("rst_done",   o_done,     1'b0);
    check("rst_fault",  o_fault,    1'b0);
    check("rst_memreq", o_mem_req,  1'b0);
    check("rst_rdata",  o_rdata,    32'h0);
    check("rst_maddr",  o_mem_addr, 32'h0);
    check("rst_mbe",    o_mem_be,   4'h0);
    check("rst_mwdata", o_mem_wdata, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;

    run_op("lb",     1'b0, F3_B,  32'h0000_1003, 32'h0,         32'h80FF_1234, 0, 1'b0);
    run_op("sh",     1'b1, F3_H,  32'h0000_2002, 32'h0000_ABCD, 32'h0,         0, 1'b0);
    run_op("lw_mis", 1'b0, F3_W,  32'h0000_3001, 32'h0,         32'h0,         0, 1'b0);
    run_op("lhu",    1'b0, F3_HU, 32'h0000_4000, 32'h0,         32'h1234_F00D, 5, 1'b1);
    run_op("lh",     1'b0, F3_H,  32'h0000_4002, 32'h0,         32'h8001_0000, 1, 1'b0);
    run_op("lbu",    1'b0, F3_BU, 32'h0000_5002, 32'h0,         32'h00A5_0000, 2, 1'b0);
    run_op("sb",     1'b1, F3_B,  32'h0000_6001, 32'h1234_56EE, 32'h0,         0, 1'b0);
    run_op("sw",     1'b1, F3_W,  32'h0000_7000, 32'hCAFE_F00D, 32'h0,         3, 1'b0);
    run_op("lw",     1'b0, F3_W,  32'h0000_8000, 32'h0,         32'h1357_9BDF, 0, 1'b0);
    run_op("f3_011", 1'b0, 3'b011, 32'h0000_9000, 32'h0,        32'h0,         0, 1'b0);
    run_op("sbu",    1'b1, F3_BU, 32'h0000_9004, 32'h0,         32'h0,         0, 1'b0);
    run_op("lh_mis", 1'b0, F3_H,  32'h0000_9001, 32'h0,         32'h0,         0, 1'b0);
    run_op("sw_mis", 1'b1, F3_W,  32'h0000_9002, 32'h0,         32'h0,         0, 1'b0);
    run_op("lb_pos", 1'b0, F3_B,  32'h0000_A000, 32'h0,         32'h0000_007F, 0, 1'b0);

    // Reset in the middle of REQ, then a stale ack
    @(negedge i_clk);
    i_valid = 1'b1; i_we = 1'b0; i_funct3 = F3_W; i_addr = 32'h0000_B000;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    @(negedge i_clk);
    check("mid_req", o_mem_req, 1'b1);
    #2 i_rst = 1'b1;
    #1;
    check("mid_rst_ready",  o_ready,    1'b1);
    check("mid_rst_memreq", o_mem_req,  1'b0);
    check("mid_rst_rdata",  o_rdata,    32'h0);
    check("mid_rst_maddr",  o_mem_addr, 32'h0);
    #1 i_rst = 1'b0;
    model_rdata = '0;
    @(negedge i_clk);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h5555_AAAA;
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      i_mem_ack = 1'b0;
      if (o_done) done_seen++;
    end
    check("stale_ack_done",  done_seen, 0);
    check("stale_ack_ready", o_ready,   1'b1);
    check("stale_ack_rdata", o_rdata,   32'h0);

`ifdef LAKE_LSU_TIMEOUT_EN
    run_op("tmo", 1'b0, F3_W, 32'h0000_C000, 32'h0, 32'h0, -1, 1'b0);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
